key_display_ctrl: RTL and testbench

Display controller that sits directly upstream of the six seven-segment digit decoders on the cracker board. It tracks the key-search lifecycle and drives one 5-bit digit code per HEX display. Codes are 0–15 for hex digits, 16 for dash and 17 for blank. While the search runs it shows a rate-limited snapshot of the key under test; at the end it shows the recovered key, or all dashes if no key was found.

---
 rtl/key_display_ctrl.sv | 156 +++++++++++++++
 tb/tb_key_display_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/key_display_ctrl.sv
// Six-digit display controller for the key-search lifecycle: blank, live key snapshots, found key, or dashes.
// Optional found-key blink compiled in with `define KEY_DISPLAY_BLINK_EN.
module key_display_ctrl #(
  parameter int SAMPLE_CYCLES = 5000000,
  parameter int BLINK_CYCLES  = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] cur_key,
  input  logic        done,
  input  logic        key_found,
  input  logic [23:0] found_key,
  output logic [4:0]  hex0,
  output logic [4:0]  hex1,
  output logic [4:0]  hex2,
  output logic [4:0]  hex3,
  output logic [4:0]  hex4,
  output logic [4:0]  hex5,
  output logic        busy
);

  localparam logic [4:0] CODE_DASH  = 5'd16;
  localparam logic [4:0] CODE_BLANK = 5'd17;

  localparam int SW = (SAMPLE_CYCLES > 2) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_FOUND,
    ST_FAIL
  } state_t;

  state_t        state_q, state_d;
  logic [23:0]   key_q, key_d;
  logic [SW-1:0] sample_cnt_q, sample_cnt_d;
  logic [4:0]    hex_q [6];
  logic [4:0]    hex_d [6];
  logic          busy_q, busy_d;
  logic          blank_found;
  logic [4:0]    key_code [6];

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_nib
      assign key_code[gi] = {1'b0, key_d[4*gi+3:4*gi]};
    end
  endgenerate

`ifdef KEY_DISPLAY_BLINK_EN
  localparam int BW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_off_q, blink_off_d;

  // Blink phase only advances while staying in FOUND; any entry or exit restarts it showing the key.
  always_comb begin
    blink_cnt_d = '0;
    blink_off_d = 1'b0;
    if (state_q == ST_FOUND && state_d == ST_FOUND) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_off_d = blink_off_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
    end
  end

  assign blank_found = blink_off_d;
`else
  assign blank_found = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    sample_cnt_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SEARCH;
          key_d   = cur_key;
        end
      end
      ST_SEARCH: begin
        // done beats both a coincident start and a coincident sample wrap.
        if (done) begin
          state_d = key_found ? ST_FOUND : ST_FAIL;
          if (key_found) key_d = found_key;
        end else if (sample_cnt_q == SAMPLE_LAST) begin
          key_d = cur_key;
        end else begin
          sample_cnt_d = sample_cnt_q + 1'b1;
        end
      end
      default: begin
        if (start) begin
          state_d = ST_SEARCH;
          key_d   = cur_key;
        end
      end
    endcase
  end

  always_comb begin
    busy_d = (state_d == ST_SEARCH);
    for (int i = 0; i < 6; i++) begin
      hex_d[i] = CODE_BLANK;
      case (state_d)
        ST_SEARCH: hex_d[i] = key_code[i];
        ST_FOUND:  hex_d[i] = blank_found ? CODE_BLANK : key_code[i];
        ST_FAIL:   hex_d[i] = CODE_DASH;
        default:   hex_d[i] = CODE_BLANK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      key_q        <= '0;
      sample_cnt_q <= '0;
      busy_q       <= 1'b0;
      for (int i = 0; i < 6; i++) hex_q[i] <= CODE_BLANK;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      sample_cnt_q <= sample_cnt_d;
      busy_q       <= busy_d;
      for (int i = 0; i < 6; i++) hex_q[i] <= hex_d[i];
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];
  assign busy = busy_q;

endmodule

// File: tb/tb_key_display_ctrl.sv
// Self-checking bench for key_display_ctrl: directed vector table, corner sequences, randomized run vs. model.
module tb_key_display_ctrl;

  localparam int S = 4;
  localparam int B = 3;

  logic        clk = 1'b0;
  logic        rst, start, done, key_found;
  logic [23:0] cur_key, found_key;
  logic [4:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  key_display_ctrl #(.SAMPLE_CYCLES(S), .BLINK_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .start(start), .cur_key(cur_key), .done(done),
    .key_found(key_found), .found_key(found_key),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .busy(busy)
  );

  // Observation word: {busy, hex5, hex4, hex3, hex2, hex1, hex0}
  function automatic logic [30:0] pk_key(input logic b, input logic [23:0] k);
    logic [30:0] r;
    r[30] = b;
    for (int n = 0; n < 6; n++) r[5*n +: 5] = {1'b0, k[4*n +: 4]};
    return r;
  endfunction

  function automatic logic [30:0] pk_all(input logic b, input logic [4:0] c);
    logic [30:0] r;
    r[30] = b;
    for (int n = 0; n < 6; n++) r[5*n +: 5] = c;
    return r;
  endfunction

  // Behavioural model: mode, what key is on show, and cycles elapsed since entering the mode.
  int          m_mode;  // 0 idle, 1 search, 2 found, 3 fail
  int          m_el;
  logic [23:0] m_key;

  task automatic model_step();
    if (rst) begin
      m_mode = 0; m_el = 0;
    end else begin
      case (m_mode)
        0: if (start) begin m_mode = 1; m_el = 0; m_key = cur_key; end
        1: begin
          if (done) begin
            m_mode = key_found ? 2 : 3; m_el = 0;
            if (key_found) m_key = found_key;
          end else begin
            m_el++;
            if (m_el % S == 0) m_key = cur_key;
          end
        end
        default: begin
          if (start) begin m_mode = 1; m_el = 0; m_key = cur_key; end
          else m_el++;
        end
      endcase
    end
  endtask

  function automatic logic [30:0] model_exp();
    case (m_mode)
      0: return pk_all(1'b0, 5'd17);
      1: return pk_key(1'b1, m_key);
      2: begin
`ifdef KEY_DISPLAY_BLINK_EN
        if ((m_el / B) % 2 == 1) return pk_all(1'b0, 5'd17);
`endif
        return pk_key(1'b0, m_key);
      end
      default: return pk_all(1'b0, 5'd16);
    endcase
  endfunction

  // One clock: model follows the inputs sampled at the edge, then outputs are compared #1 later.
  task automatic tick(input string name, input bit use_exp, input logic [30:0] exp_in);
    logic [30:0] obs, exp_v;
    model_step();
    @(posedge clk);
    #1;
    obs = {busy, hex5, hex4, hex3, hex2, hex1, hex0};
    exp_v = use_exp ? exp_in : model_exp();
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got busy=%0b hex5..0=%0d,%0d,%0d,%0d,%0d,%0d required busy=%0b hex5..0=%0d,%0d,%0d,%0d,%0d,%0d",
               name, obs[30], obs[29:25], obs[24:20], obs[19:15], obs[14:10], obs[9:5], obs[4:0],
               exp_v[30], exp_v[29:25], exp_v[24:20], exp_v[19:15], exp_v[14:10], exp_v[9:5], exp_v[4:0]);
    end
  endtask

  task automatic idle_inputs();
    rst = 0; start = 0; done = 0; key_found = 0;
  endtask

  typedef struct {
    logic        rst, start, done, kf;
    logic [23:0] cur, fnd;
    logic [30:0] exp;
  } vec_t;

  vec_t tbl [19];

  initial begin
    m_mode = 0; m_el = 0; m_key = '0;
    rst = 1; start = 0; done = 0; key_found = 0; cur_key = '0; found_key = '0;

    tbl[0]  = '{1, 1, 1, 0, 24'h000000, 24'h000000, pk_all(0, 17)};
    tbl[1]  = '{1, 0, 1, 1, 24'hFFFFFF, 24'h111111, pk_all(0, 17)};
    tbl[2]  = '{0, 0, 0, 0, 24'h000000, 24'h000000, pk_all(0, 17)};
    tbl[3]  = '{0, 1, 0, 0, 24'h123456, 24'h000000, pk_key(1, 24'h123456)};
    tbl[4]  = '{0, 0, 0, 0, 24'h123457, 24'h000000, pk_key(1, 24'h123456)};
    tbl[5]  = '{0, 0, 0, 0, 24'h123458, 24'h000000, pk_key(1, 24'h123456)};
    tbl[6]  = '{0, 0, 0, 0, 24'h123459, 24'h000000, pk_key(1, 24'h123456)};
    tbl[7]  = '{0, 0, 0, 0, 24'h12345A, 24'h000000, pk_key(1, 24'h12345A)};
    tbl[8]  = '{0, 0, 0, 0, 24'h12345B, 24'h000000, pk_key(1, 24'h12345A)};
    tbl[9]  = '{0, 0, 0, 0, 24'h12345C, 24'h000000, pk_key(1, 24'h12345A)};
    tbl[10] = '{0, 0, 0, 0, 24'h12345D, 24'h000000, pk_key(1, 24'h12345A)};
    tbl[11] = '{0, 0, 1, 1, 24'h12345E, 24'hABCDEF, pk_key(0, 24'hABCDEF)};
    tbl[12] = '{0, 0, 0, 0, 24'h12345F, 24'h000000, pk_key(0, 24'hABCDEF)};
    tbl[13] = '{0, 1, 1, 1, 24'h000777, 24'h999999, pk_key(1, 24'h000777)};
    tbl[14] = '{0, 1, 1, 0, 24'h000888, 24'h000000, pk_all(0, 16)};
    tbl[15] = '{0, 0, 0, 0, 24'h000999, 24'h000000, pk_all(0, 16)};
    tbl[16] = '{1, 0, 0, 0, 24'h000000, 24'h000000, pk_all(0, 17)};
    tbl[17] = '{0, 1, 1, 1, 24'h0000AA, 24'hABCDEF, pk_key(1, 24'h0000AA)};
    tbl[18] = '{0, 0, 0, 0, 24'h0000AB, 24'h000000, pk_key(1, 24'h0000AA)};

    @(posedge clk); #1;
    for (int i = 0; i < 19; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; done = tbl[i].done; key_found = tbl[i].kf;
      cur_key = tbl[i].cur; found_key = tbl[i].fnd;
      tick($sformatf("vec%0d", i), 1'b1, tbl[i].exp);
    end

    // Found key held (steady, or blinking with period 2*B) after a done coincident with a wrap.
    idle_inputs(); cur_key = 24'h000001;
    tick("found_setup_a", 1'b1, pk_key(1, 24'h0000AA));
    tick("found_setup_b", 1'b1, pk_key(1, 24'h0000AA));
    done = 1; key_found = 1; found_key = 24'h00000F; cur_key = 24'h555555;
    tick("found_entry", 1'b1, pk_key(0, 24'h00000F));
    idle_inputs();
`ifdef KEY_DISPLAY_BLINK_EN
    for (int c = 1; c < 7; c++)
      tick($sformatf("blink_c%0d", c), 1'b1,
           (c < 3 || c >= 6) ? pk_key(0, 24'h00000F) : pk_all(0, 17));
    tick("blink_c7", 1'b1, pk_key(0, 24'h00000F));
    rst = 1;
    tick("blink_rst", 1'b1, pk_all(0, 17));
    rst = 0;
    tick("blink_rst_idle", 1'b1, pk_all(0, 17));
`else
    for (int c = 1; c <= 50; c++)
      tick($sformatf("found_hold_c%0d", c), 1'b1, pk_key(0, 24'h00000F));
`endif

    // Randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 79) == 0);
      start     = ($urandom_range(0, 15) == 0);
      done      = ($urandom_range(0, 11) == 0);
      key_found = $urandom_range(0, 1) != 0;
      cur_key   = 24'($urandom);
      found_key = 24'($urandom);
      tick($sformatf("rand%0d", c), 1'b0, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
